// File: rtl/led_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scanner_if
//  Purpose  : Serial-link inputs and row/column driver outputs of the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_matrix_scanner_if #(
   parameter int NDISP = 2,
   parameter int NCOLS = 8,
   parameter int NROWS = 8
);
   logic                   sck;
   logic                   sdi;
   logic                   load;
   logic [NROWS-1:0]       row;
   logic [NDISP*NCOLS-1:0] col;
   logic                   frame_start;
   logic                   load_err;

   modport master (
      output sck, sdi, load,
      input  row, col, frame_start, load_err
   );

   modport slave (
      input  sck, sdi, load,
      output row, col, frame_start, load_err
   );
endinterface
`default_nettype wire

// File: rtl/led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scanner
//  Purpose  : Double-buffered serial frame loader and tear-free column scanner
//             for NDISP LED matrices sharing a row bus.
//  Revision : 1.0 - initial release
// ============================================================================
module led_matrix_scanner #(
   parameter int NDISP = 2,
   parameter int NCOLS = 8,
   parameter int NROWS = 8,
   parameter int DWELL = 16384,
   parameter int BLANK = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   led_matrix_scanner_if.slave  bus
);

   localparam int C_DBITS      = NCOLS + NCOLS*NROWS;
   localparam int C_FRAME_BITS = NDISP*C_DBITS;
   localparam int C_NSLOT      = NDISP*NCOLS;
   localparam int C_DW         = (NDISP > 1) ? $clog2(NDISP) : 1;
   localparam int C_CW         = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int C_TMAX       = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int C_TW         = $clog2(C_TMAX + 1);
   localparam int C_BW         = $clog2(C_FRAME_BITS + 2);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   logic [2:0]              r_sck_pipe;
   logic [2:0]              r_load_pipe;
   logic [1:0]              r_sdi_pipe;
   logic [C_FRAME_BITS-1:0] r_shadow;
   logic [C_FRAME_BITS-1:0] r_active;
   logic [C_BW-1:0]         r_bitcnt;
   logic                    r_pending;
   logic                    r_load_err;

   state_t                  r_state, w_state_next;
   logic [C_TW-1:0]         r_cnt, w_cnt_next;
   logic [C_DW-1:0]         r_disp, w_disp_next;
   logic [C_CW-1:0]         r_colidx, w_colidx_next;
   logic [NROWS-1:0]        r_row, w_row_next;
   logic [C_NSLOT-1:0]      r_col, w_col_next;
   logic                    r_frame_start, w_fs_next;
   logic                    r_running;
   logic                    w_wrap;

   // Edges are taken from the synchronized copy ([1]) against its delayed copy ([2]).
   logic w_sck_rise, w_load_rise, w_load_fall, w_shift, w_len_ok, w_commit;
   assign w_sck_rise  = r_sck_pipe[1] & ~r_sck_pipe[2];
   assign w_load_rise = r_load_pipe[1] & ~r_load_pipe[2];
   assign w_load_fall = ~r_load_pipe[1] & r_load_pipe[2];
   assign w_shift     = w_sck_rise & r_load_pipe[1];
   assign w_len_ok    = (r_bitcnt == C_BW'(C_FRAME_BITS));
   // A frame whose load falls on the wrap cycle still commits; a new load rise cancels it.
   assign w_commit    = w_wrap & (r_pending | (w_load_fall & w_len_ok)) & ~w_load_rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sck_pipe  <= '0;
         r_load_pipe <= '0;
         r_sdi_pipe  <= '0;
         r_shadow    <= '0;
         r_active    <= '0;
         r_bitcnt    <= '0;
         r_pending   <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_sck_pipe  <= {r_sck_pipe[1:0], bus.sck};
         r_load_pipe <= {r_load_pipe[1:0], bus.load};
         r_sdi_pipe  <= {r_sdi_pipe[0], bus.sdi};

         if (w_load_rise) begin
            r_bitcnt <= '0;
         end else if (w_shift) begin
            r_shadow <= {r_shadow[C_FRAME_BITS-2:0], r_sdi_pipe[1]};
            if (r_bitcnt != C_BW'(C_FRAME_BITS + 1))
               r_bitcnt <= r_bitcnt + 1'b1;
         end

         if (w_load_fall && !w_len_ok)
            r_load_err <= 1'b1;

         if (w_load_rise || w_commit)
            r_pending <= 1'b0;
         else if (w_load_fall && w_len_ok)
            r_pending <= 1'b1;

         if (w_commit)
            r_active <= r_shadow;
      end
   end

   logic [NCOLS-1:0] w_en   [NDISP];
   logic [NROWS-1:0] w_rows [NDISP][NCOLS];
   logic [C_NSLOT-1:0] w_onehot;

   // Display 0 occupies the most significant block, colsOn at the top of each block.
   for (genvar d = 0; d < NDISP; d++) begin : g_disp
      localparam int C_LSB = (NDISP - 1 - d)*C_DBITS;
      assign w_en[d] = r_active[C_LSB + NCOLS*NROWS +: NCOLS];
      for (genvar c = 0; c < NCOLS; c++) begin : g_col
         assign w_rows[d][c] = r_active[C_LSB + (NCOLS - 1 - c)*NROWS +: NROWS];
      end
   end

   for (genvar k = 0; k < C_NSLOT; k++) begin : g_slot
      assign w_onehot[k] = (r_disp == C_DW'(k / NCOLS)) && (r_colidx == C_CW'(k % NCOLS));
   end

   always_comb begin
      w_state_next  = r_state;
      w_cnt_next    = r_cnt + 1'b1;
      w_disp_next   = r_disp;
      w_colidx_next = r_colidx;
      w_row_next    = r_row;
      w_col_next    = r_col;
      w_fs_next     = 1'b0;
      w_wrap        = 1'b0;
      if (!r_running) begin
         // First edge after reset enters slot 0 blank and announces the frame.
         w_fs_next  = 1'b1;
         w_cnt_next = '0;
      end else begin
         case (r_state)
            ST_BLANK: begin
               if (r_cnt == C_TW'(BLANK - 1)) begin
                  w_state_next = ST_DRIVE;
                  w_cnt_next   = '0;
                  if (w_en[r_disp][r_colidx]) begin
                     w_row_next = w_rows[r_disp][r_colidx];
                     w_col_next = w_onehot;
                  end else begin
                     w_row_next = '0;
                     w_col_next = '0;
                  end
               end
            end
            ST_DRIVE: begin
               if (r_cnt == C_TW'(DWELL - 1)) begin
                  w_state_next = ST_BLANK;
                  w_cnt_next   = '0;
                  w_row_next   = '0;
                  w_col_next   = '0;
                  if (r_disp == C_DW'(NDISP - 1)) begin
                     w_disp_next = '0;
                     if (r_colidx == C_CW'(NCOLS - 1)) begin
                        w_colidx_next = '0;
                        w_wrap        = 1'b1;
                        w_fs_next     = 1'b1;
                     end else begin
                        w_colidx_next = r_colidx + 1'b1;
                     end
                  end else begin
                     w_disp_next = r_disp + 1'b1;
                  end
               end
            end
            default: begin
               w_state_next = ST_BLANK;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_BLANK;
         r_cnt         <= '0;
         r_disp        <= '0;
         r_colidx      <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_frame_start <= 1'b0;
         r_running     <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_cnt         <= w_cnt_next;
         r_disp        <= w_disp_next;
         r_colidx      <= w_colidx_next;
         r_row         <= w_row_next;
         r_col         <= w_col_next;
         r_frame_start <= w_fs_next;
         r_running     <= 1'b1;
      end
   end

   assign bus.row         = r_row;
   assign bus.col         = r_col;
   assign bus.frame_start = r_frame_start;
   assign bus.load_err    = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scanner
//  Purpose  : Randomized scoreboard bench for led_matrix_scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_matrix_scanner;

   localparam int NDISP = 2;
   localparam int NCOLS = 8;
   localparam int NROWS = 8;
   localparam int DWELL = 8;
   localparam int BLANK = 2;
   localparam int FB    = 144;
   localparam int SLOT  = BLANK + DWELL;
   localparam int FRAME = NDISP*NCOLS*SLOT;
   localparam int DB    = FB / NDISP;

   typedef struct {
      int          frame;
      logic [FB-1:0] data;
   } commit_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   led_matrix_scanner_if #(.NDISP(NDISP), .NCOLS(NCOLS), .NROWS(NROWS)) bus ();

   led_matrix_scanner #(
      .NDISP(NDISP), .NCOLS(NCOLS), .NROWS(NROWS), .DWELL(DWELL), .BLANK(BLANK)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int      checks   = 0;
   int      failures = 0;
   commit_t exp_q[$];
   bit      mon_en   = 1'b0;
   int      cyc      = -1;
   logic [FB-1:0] mdl_active = '0;

   // cyc numbers the cycles after the first post-reset edge (frame starts at 0).
   always @(posedge clk) begin
      if (!mon_en) cyc <= -1;
      else         cyc <= cyc + 1;
   end

   // Expected pins from frame bit order: MSB is the first bit sent.
   task automatic expect_at(input int n, input logic [FB-1:0] fr,
                            output logic [7:0] er, output logic [15:0] ec, output logic efs);
      int ph, s, p, d, c, base;
      ph  = n % FRAME;
      s   = ph / SLOT;
      p   = ph % SLOT;
      efs = (ph == 0);
      er  = '0;
      ec  = '0;
      if (p >= BLANK) begin
         d    = s % NDISP;
         c    = s / NDISP;
         base = d*DB;
         if (fr[FB-1-(base + NCOLS-1-c)]) begin
            ec[d*NCOLS + c] = 1'b1;
            for (int r = 0; r < NROWS; r++)
               er[r] = fr[FB-1-(base + NCOLS + c*NROWS + NROWS-1-r)];
         end
      end
   endtask

   always @(negedge clk) begin
      logic [7:0]  er;
      logic [15:0] ec;
      logic        efs;
      if (!mon_en || cyc < 0) begin
         mdl_active = '0;
      end else begin
         if (cyc % FRAME == 0 && exp_q.size() > 0 && exp_q[0].frame == cyc / FRAME)
            mdl_active = exp_q.pop_front().data;
         expect_at(cyc, mdl_active, er, ec, efs);
         checks++;
         if (bus.row !== er || bus.col !== ec || bus.frame_start !== efs) begin
            failures++;
            $display("FAIL pins cyc=%0d row=%h col=%h fs=%b expected row=%h col=%h fs=%b",
                     cyc, bus.row, bus.col, bus.frame_start, er, ec, efs);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int lo, input int hi);
      int k = 0;
      while (!(cyc >= 0 && (cyc % FRAME) >= lo && (cyc % FRAME) <= hi) && k < 2*FRAME) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2*FRAME) begin
         checks++;
         failures++;
         $display("FAIL wait_phase timeout lo=%0d hi=%0d", lo, hi);
      end
   endtask

   task automatic wait_commit();
      int k = 0;
      while (exp_q.size() > 0 && k < 3*FRAME) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL wait_commit timeout pending=%0d", exp_q.size());
      end
   endtask

   // A load rise cancels an uncommitted frame unless its wrap is already past.
   task automatic load_rise();
      bus.load = 1'b1;
      if (exp_q.size() > 0 && cyc + 2 < FRAME * exp_q[$].frame)
         void'(exp_q.pop_back());
   endtask

   task automatic send(input logic [159:0] bits, input int nbits, input int fall_slot);
      load_rise();
      tick(4);
      for (int i = nbits - 1; i >= 0; i--) begin
         bus.sdi = bits[i];
         tick(3);
         bus.sck = 1'b1;
         tick(3);
         bus.sck = 1'b0;
      end
      tick(4);
      if (fall_slot >= 0)
         wait_phase(fall_slot*SLOT, fall_slot*SLOT + SLOT - 1);
      bus.load = 1'b0;
      if (nbits == FB)
         exp_q.push_back('{frame: (cyc + 2) / FRAME + 1, data: bits[FB-1:0]});
   endtask

   function automatic logic [159:0] rand_bits();
      logic [159:0] v;
      for (int i = 0; i < 5; i++)
         v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   logic [FB-1:0] pat1;

   initial begin
      pat1     = {8'hFF, 8'hA5, 56'h0, 8'h01, 8'h3C, 56'h0};
      bus.sck  = 1'b0;
      bus.sdi  = 1'b0;
      bus.load = 1'b0;
      tick(3);
      check("reset_row", 32'(bus.row), 32'h0);
      check("reset_col", 32'(bus.col), 32'h0);
      check("reset_fs", 32'(bus.frame_start), 32'h0);
      check("reset_err", 32'(bus.load_err), 32'h0);

      reset  = 1'b1;
      mon_en = 1'b1;
      tick(2*FRAME + 5);
      check("err_idle", 32'(bus.load_err), 32'h0);

      // Reference frame, committed at a wrap and observed for a full frame.
      send({16'h0, pat1}, FB, -1);
      wait_commit();
      tick(FRAME);

      // Short and long transfers flag an error and leave the display alone.
      send(rand_bits(), 100, -1);
      tick(6);
      check("err_after_100", 32'(bus.load_err), 32'h1);
      send(rand_bits(), 150, -1);
      tick(6);
      check("err_after_150", 32'(bus.load_err), 32'h1);
      tick(FRAME);

      // Transfer finishing in slot 5 shows only from the next frame.
      send(rand_bits(), FB, 5);
      wait_commit();
      tick(FRAME);

      // Second transfer starts before the wrap and supersedes the first.
      send(rand_bits(), FB, 2);
      tick(20);
      send(rand_bits(), FB, -1);
      wait_commit();
      tick(FRAME);
      check("err_sticky", 32'(bus.load_err), 32'h1);

      // Asynchronous reset while the A5 column is driven.
      send({16'h0, pat1}, FB, -1);
      wait_commit();
      wait_phase(BLANK + 2, BLANK + 2);
      check("row_before_reset", 32'(bus.row), 32'hA5);
      @(posedge clk);
      #2;
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check("async_row", 32'(bus.row), 32'h0);
      check("async_col", 32'(bus.col), 32'h0);
      exp_q.delete();
      tick(3);
      check("err_cleared", 32'(bus.load_err), 32'h0);
      reset  = 1'b1;
      mon_en = 1'b1;
      tick(2*FRAME + 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
